seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
Upstream driver for the seven-segment decoder stage. It time-multiplexes the four display digits by generating the 2-bit digit select (anode_sel) from a refresh prescaler. It also presents a stable 16-bit display word (data_out) to the decoder. New values written by the host are double-buffered and committed only at a frame boundary, so no digit ever shows a mix of old and new data within one scan.

Parameters:
TICKS_PER_DIGIT, 100000, enabled clock cycles each digit is held (100 MHz gives 1 kHz digit rate, 250 Hz frame rate); legal range is 1 to 2^CNT_WIDTH-1
CNT_WIDTH, 17, prescaler width in bits; must hold TICKS_PER_DIGIT-1

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  1 = scanning runs; 0 = prescaler and anode_sel freeze
wr_en  input  1  one-cycle write strobe for data_in
data_in  input  16  new display word, 4 bits per digit, digit 3 in [15:12]
data_out  output  16  committed display word to the decoder
anode_sel  output  2  current digit index to the decoder
frame_tick  output  1  one-cycle pulse at each frame boundary
pending  output  1  1 = a written word is waiting to be committed

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: while rst=1 at a rising edge, all of the following clear; rst overrides wr_en and enable in that cycle:
  - prescaler = 0, anode_sel = 2'b00, data_out = 16'h0000
  - shadow register = 16'h0000, pending = 0, frame_tick = 0
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Prescaler:
  - When enable=1, it counts 0..TICKS_PER_DIGIT-1.
  - When count = TICKS_PER_DIGIT-1 and enable=1, digit_tick (internal) is asserted and the count wraps to 0 on the next edge.
  - When enable=0, the count holds and no digit_tick occurs.
  - With TICKS_PER_DIGIT=1, digit_tick is asserted on every enabled cycle.
- Digit scan:
  - On each digit_tick, anode_sel advances 00→01→10→11→00 with modulo-4 wrap.
  - anode_sel changes only on digit_tick.
- Frame boundary: a digit_tick while anode_sel = 2'b11. On that edge:
  - anode_sel becomes 2'b00.
  - frame_tick = 1 for exactly one cycle, aligned with the first cycle in which anode_sel = 00.
  - If pending=1: data_out <= shadow and pending <= 0.
  - If pending=0: data_out holds.
- Write handshake:
  - wr_en=1 loads shadow <= data_in and sets pending <= 1. It never changes data_out directly except in the simultaneous case below.
  - Multiple writes before a boundary: the last write wins; earlier writes are discarded.
  - wr_en and the frame boundary in the same cycle: data_out <= data_in (bypass, newest wins) and pending <= 0.
- Freeze: with enable=0, writes still load shadow and set pending. The commit waits until scanning resumes and reaches a boundary.
- Outside the frame boundary, frame_tick = 0.
- Latency from wr_en to visible data_out is 1 to 4*TICKS_PER_DIGIT cycles when enable is held at 1.

Test Plan:
All scenarios use TICKS_PER_DIGIT=4 and CNT_WIDTH=3.
- Reset then enable=1 for 40 cycles → anode_sel steps 0,1,2,3,0,… with each value held exactly 4 cycles; frame_tick pulses every 16 cycles, on the first cycle of anode_sel=0; data_out=16'h0000 and pending=0 throughout.
- wr_en with data_in=16'h1234 at cycle 2 of digit 1 → pending=1 the next cycle; data_out stays 0000 until the edge where anode_sel goes 3→0; then data_out=16'h1234, pending=0, frame_tick=1 in that same cycle.
- Writes of 16'hAAAA then 16'hBEEF within one frame → data_out goes directly 0000→BEEF at the boundary; AAAA never appears.
- wr_en with data_in=16'hC0DE in the exact frame-boundary cycle, while pending holds 16'h5555 → data_out=16'hC0DE on that edge, pending=0; 5555 never appears.
- enable=0 for 10 cycles mid-digit 2 → anode_sel and the prescaler hold; no frame_tick; a write made during the freeze keeps pending=1 and commits only at the first boundary after enable returns to 1.
- rst=1 asserted mid-frame, with pending=1 and wr_en=1 in the same cycle → next cycle: anode_sel=0, data_out=0000, pending=0, frame_tick=0; scanning restarts with a full 4-cycle digit 0.

Source files
------------

// File: rtl/seven_seg_if.sv
// Host/decoder-facing bundle for the seven-segment scanner.
// The master (host) drives scan enable and writes. The slave (scanner)
// returns the committed word, the digit select and the status flags.
interface seven_seg_if;
  logic        enable;
  logic        wr_en;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [1:0]  anode_sel;
  logic        frame_tick;
  logic        pending;

  modport master (
    output enable, wr_en, data_in,
    input  data_out, anode_sel, frame_tick, pending
  );

  modport slave (
    input  enable, wr_en, data_in,
    output data_out, anode_sel, frame_tick, pending
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit scan driver for the seven-segment decoder.
// A prescaler paces the digit select. Host writes land in a shadow register
// and reach data_out only at a frame boundary, so a scan never mixes words.
module seven_seg_scanner #(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int CNT_WIDTH       = 17
) (
  input logic       clk,
  input logic       rst,
  seven_seg_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LAST_TICK = CNT_WIDTH'(TICKS_PER_DIGIT - 1);

  logic [CNT_WIDTH-1:0] presc_cnt;
  logic [1:0]           anode_q;
  logic [15:0]          shadow_q;
  logic [15:0]          data_q;
  logic                 pending_q;
  logic                 frame_q;

  logic digit_tick;
  logic frame_boundary;

  // Digit advance and frame boundary, decoded from the current count and digit
  always_comb begin
    digit_tick     = bus.enable && (presc_cnt == LAST_TICK);
    frame_boundary = digit_tick && (anode_q == 2'b11);
  end

  // Refresh prescaler: counts enabled cycles within one digit, holds while frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (bus.enable) begin
      if (digit_tick) presc_cnt <= '0;
      else            presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // Digit select: advances modulo 4 on each digit tick; frame_tick marks digit 0 entry
  always_ff @(posedge clk) begin
    if (rst) begin
      anode_q <= 2'b00;
      frame_q <= 1'b0;
    end else begin
      if (digit_tick) anode_q <= anode_q + 2'd1;
      frame_q <= frame_boundary;
    end
  end

  // Double buffer: writes go to the shadow; commit at the boundary, with a write
  // landing on the boundary itself bypassing the shadow so the newest word wins
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= 16'h0000;
      data_q    <= 16'h0000;
      pending_q <= 1'b0;
    end else begin
      if (bus.wr_en) shadow_q <= bus.data_in;
      if (frame_boundary) begin
        if (bus.wr_en)     data_q <= bus.data_in;
        else if (pending_q) data_q <= shadow_q;
        pending_q <= 1'b0;
      end else if (bus.wr_en) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.anode_sel  = anode_q;
  assign bus.frame_tick = frame_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with TICKS_PER_DIGIT=4, CNT_WIDTH=3.
// The reference tracks the total number of enabled cycles since reset and
// derives digit index and frame boundaries from it arithmetically.
module tb_seven_seg_scanner;

  localparam int T     = 4;
  localparam int CW    = 3;
  localparam int FRAME = 4 * T;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seven_seg_if bus ();

  seven_seg_scanner #(.TICKS_PER_DIGIT(T), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [1:0]  anode;
    logic [15:0] dout;
    logic        ft;
    logic        pend;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // reference model state
  int          m_en_cycles = 0;
  logic [15:0] m_shadow    = 16'h0;
  logic [15:0] m_dout      = 16'h0;
  logic        m_pend      = 1'b0;
  logic        m_ft        = 1'b0;

  function automatic logic next_is_boundary(input logic en);
    return en && (((m_en_cycles + 1) % FRAME) == 0);
  endfunction

  task automatic model_update(input logic r, input logic en, input logic w,
                              input logic [15:0] d);
    logic bnd;
    exp_t e;
    if (r) begin
      m_en_cycles = 0;
      m_shadow    = 16'h0;
      m_dout      = 16'h0;
      m_pend      = 1'b0;
      m_ft        = 1'b0;
    end else begin
      bnd = next_is_boundary(en);
      if (en) m_en_cycles++;
      m_ft = bnd;
      if (bnd) begin
        if (w)           m_dout = d;
        else if (m_pend) m_dout = m_shadow;
        m_pend = 1'b0;
      end else if (w) begin
        m_pend = 1'b1;
      end
      if (w) m_shadow = d;
    end
    e.cyc   = cyc;
    e.anode = 2'((m_en_cycles / T) % 4);
    e.dout  = m_dout;
    e.ft    = m_ft;
    e.pend  = m_pend;
    q.push_back(e);
  endtask

  task automatic step(input logic r, input logic en, input logic w,
                      input logic [15:0] d);
    @(negedge clk);
    rst         = r;
    bus.enable  = en;
    bus.wr_en   = w;
    bus.data_in = d;
    @(posedge clk);
    cyc++;
    model_update(r, en, w, d);
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 16'h0);
  endtask

  task automatic check(input string name, input int c, input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
    end
  endtask

  // Monitor: the DUT presents registered outputs every cycle; compare off-edge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("anode_sel",  e.cyc, 16'(bus.anode_sel),  16'(e.anode));
      check("data_out",   e.cyc, bus.data_out,        e.dout);
      check("frame_tick", e.cyc, 16'(bus.frame_tick), 16'(e.ft));
      check("pending",    e.cyc, 16'(bus.pending),    16'(e.pend));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.enable  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.data_in = 16'h0;

    // reset, then free-running scan
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    run(40, 1'b1);

    // single write in digit 1, committed at the next boundary
    while (((m_en_cycles / T) % 4) != 1 || (m_en_cycles % T) != 2) run(1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    run(FRAME + 2, 1'b1);

    // two writes in one frame: last write wins
    step(1'b0, 1'b1, 1'b1, 16'hAAAA);
    run(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'hBEEF);
    run(FRAME, 1'b1);

    // write landing exactly on the boundary while another word is pending
    step(1'b0, 1'b1, 1'b1, 16'h5555);
    while (!next_is_boundary(1'b1)) run(1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'hC0DE);
    run(FRAME + 2, 1'b1);

    // freeze mid digit 2 with a write during the freeze
    while (((m_en_cycles / T) % 4) != 2 || (m_en_cycles % T) != 1) run(1, 1'b1);
    run(4, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h7E57);
    run(5, 1'b0);
    run(FRAME + 4, 1'b1);

    // reset mid-frame with pending set and a simultaneous write
    step(1'b0, 1'b1, 1'b1, 16'h9999);
    run(2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'hF00D);
    run(FRAME + 4, 1'b1);

    // boundary write with nothing pending, then random traffic
    while (!next_is_boundary(1'b1)) run(1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'h3C3C);
    for (int i = 0; i < 400; i++) begin
      logic r, en, w;
      logic [15:0] d;
      r  = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 9) != 0);
      w  = ($urandom_range(0, 5) == 0);
      d  = 16'($urandom);
      step(r, en, w, d);
    end

    // let the monitor drain the final expectation
    @(negedge clk);
    @(posedge clk);
    check("queue_drained", cyc, 16'(q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
